// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: opcodes, state encodings and control-field constants for the multicycle MIPS controller
package mips_mc_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_HALT   = 4'd15
  } state_t;
  localparam logic [1:0] ALUOP_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_SUB    = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT  = 2'd2;
  localparam logic [1:0] ALUB_REG     = 2'd0;
  localparam logic [1:0] ALUB_FOUR    = 2'd1;
  localparam logic [1:0] ALUB_IMM     = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  function automatic logic is_mem_state(state_t s);
    return s == S_FETCH || s == S_MEMRD || s == S_MEMWR;
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive not-ready memory cycles and flags when the tolerated limit is hit
module mem_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic expired
);
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  // expiry forces a state change, so the count restarts from zero alongside it
  always_comb begin
    expired = en && cnt_q == WAIT_W'(MAX_WAIT);
    cnt_d = (en && !expired) ? cnt_q + 1'b1 : '0;
  end
  // count register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM sequencing a shared multicycle MIPS datapath
module multicycle_ctrl
  import mips_mc_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       trap,
  output logic [3:0] state
);
  state_t state_q, state_d;
  logic wait_en, expired, unused;
  assign state = state_q;
  assign wait_en = is_mem_state(state_q) && !mem_ready;
  assign unused = zero;
  mem_wait_timer #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) u_timer (
    .clk(clk),
    .rst(reset),
    .en(wait_en),
    .expired(expired)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;
  // next state and per-state control outputs
  always_comb begin
    state_d = state_q;
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = ALUB_REG;
    alu_op = ALUOP_ADD;
    pc_source = PCSRC_ALU;
    illegal_op = 1'b0;
    trap = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        alu_src_b = ALUB_FOUR;
        ir_write = mem_ready;
        pc_write = mem_ready;
        state_d = mem_ready ? S_DECODE : expired ? S_HALT : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = ALUB_IMM_SH2;
        case (opcode)
          OP_RTYPE: state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ: state_d = S_BRANCH;
          OP_J: state_d = S_JUMP;
          OP_ADDI: state_d = S_ADDIEX;
          default: begin
            illegal_op = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        state_d = opcode == OP_LW ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d = 1'b1;
        state_d = mem_ready ? S_MEMWB : expired ? S_HALT : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d = 1'b1;
        state_d = mem_ready ? S_FETCH : expired ? S_HALT : S_MEMWR;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source = PCSRC_ALUOUT;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: trap = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: instruction-level reference sequences checked cycle by cycle against the controller
module tb_multicycle_ctrl;
  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMRD = 4'd4,
    MEMWB = 4'd5, MEMWR = 4'd6, EXEC = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9, JUMP = 4'd10,
    ADDIEX = 4'd11, ADDIWB = 4'd12, HALT = 4'd15;
  logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst;
  logic reg_write, alu_src_a, illegal_op, trap;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [17:0] ctl;
  int total = 0, bad = 0;
  multicycle_ctrl #(.MAX_WAIT(15), .WAIT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .trap(trap), .state(state)
  );
  always #5 clk = ~clk;
  assign ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, trap};
  // expected control word for a state, straight from the per-state output table
  function automatic logic [17:0] exp_ctl(logic [3:0] st, logic rdy, logic [5:0] op);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill, tr;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill, tr} = '0;
    {asb, aop, psrc} = '0;
    case (st)
      FETCH: begin mr = 1; asb = 2'd1; irw = rdy; pw = rdy; end
      DECODE: begin asb = 2'd3; ill = !(op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08}); end
      MEMADR: begin asa = 1; asb = 2'd2; end
      MEMRD: begin mr = 1; iod = 1; end
      MEMWB: begin rw = 1; m2r = 1; end
      MEMWR: begin mw = 1; iod = 1; end
      EXEC: begin asa = 1; aop = 2'd2; end
      ALUWB: begin rw = 1; rd = 1; end
      BRANCH: begin asa = 1; aop = 2'd1; pwc = 1; psrc = 2'd1; end
      JUMP: begin pw = 1; psrc = 2'd2; end
      ADDIEX: begin asa = 1; asb = 2'd2; end
      ADDIWB: rw = 1;
      HALT: tr = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill, tr};
  endfunction
  // one clock cycle: drive inputs after the falling edge, then check state and controls
  task automatic cyc(input logic [3:0] st, input logic rdy, input logic [5:0] op);
    @(negedge clk);
    mem_ready = rdy;
    opcode = op;
    zero = 1'($urandom);
    #1;
    total++;
    assert (state === st) else begin
      bad++;
      $error("FAIL state: got %0d want %0d (op %h)", state, st, op);
    end
    total++;
    assert (ctl === exp_ctl(st, rdy, op)) else begin
      bad++;
      $error("FAIL ctl[st=%0d]: got %b want %b", st, ctl, exp_ctl(st, rdy, op));
    end
  endtask
  // memory phase: w not-ready cycles, then the completing one
  task automatic phase(input logic [3:0] st, input int w, input logic [5:0] op);
    for (int i = 0; i < w; i++) cyc(st, 1'b0, op);
    cyc(st, 1'b1, op);
  endtask
  // whole instruction as the state path its class must walk
  task automatic instr(input logic [5:0] op, input int wf, input int wm);
    phase(FETCH, wf, op);
    cyc(DECODE, 1'($urandom), op);
    case (op)
      6'h00: begin cyc(EXEC, 1'($urandom), op); cyc(ALUWB, 1'($urandom), op); end
      6'h23: begin cyc(MEMADR, 1'($urandom), op); phase(MEMRD, wm, op); cyc(MEMWB, 1'($urandom), op); end
      6'h2B: begin cyc(MEMADR, 1'($urandom), op); phase(MEMWR, wm, op); end
      6'h04: cyc(BRANCH, 1'($urandom), op);
      6'h02: cyc(JUMP, 1'($urandom), op);
      6'h08: begin cyc(ADDIEX, 1'($urandom), op); cyc(ADDIWB, 1'($urandom), op); end
      default: ;
    endcase
  endtask
  function automatic int rand_wait();
    return ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
  endfunction
  function automatic logic [5:0] rand_op();
    logic [5:0] legal [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    logic [5:0] o;
    if ($urandom_range(0, 6) != 0) return legal[$urandom_range(0, 5)];
    do o = 6'($urandom); while (o inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08});
    return o;
  endfunction
  initial begin
    repeat (3) cyc(IDLE, 1'b1, 6'h00);
    reset = 1'b0;
    instr(6'h23, 0, 0);
    instr(6'h2B, 0, 3);
    instr(6'h04, 0, 0);
    instr(6'h02, 0, 0);
    instr(6'h3F, 0, 0);
    instr(6'h00, 15, 0);
    instr(6'h23, 2, 15);
    instr(6'h08, 1, 0);
    for (int n = 0; n < 40; n++) instr(rand_op(), rand_wait(), rand_wait());
    for (int i = 0; i < 16; i++) cyc(FETCH, 1'b0, 6'h00);
    repeat (4) cyc(HALT, 1'($urandom), rand_op());
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    assert (state === IDLE && trap === 1'b0 && ctl === 18'd0) else begin
      bad++;
      $error("FAIL async_reset: got state %0d trap %b ctl %b want 0 0 0", state, trap, ctl);
    end
    @(negedge clk);
    reset = 1'b0;
    instr(6'h2B, 0, 0);
    instr(6'h23, 0, 0);
    for (int i = 0; i < 16; i++) cyc(FETCH, 1'b0, 6'h23);
    cyc(HALT, 1'b1, 6'h23);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences a shared multicycle MIPS datapath: one unified memory port, one ALU, and an instruction register.
- Replaces the single-cycle opcode decoder.
- Asserts per-state enables and mux selects for the PC, IR, register file, memory and ALU.
- Stalls in any memory state until the memory signals ready; enters a trap state on wait timeout.

Parameters:
MAX_WAIT, 15, max consecutive not-ready cycles tolerated in a memory state before trap (1..255)
WAIT_W, 8, width of wait counter; must satisfy 2^WAIT_W > MAX_WAIT

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
opcode  in  6  instruction[31:26], taken from the IR output
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if zero (beq)
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
mem_to_reg  out  1  write-back select: 0=ALUOut, 1=MDR
reg_dst  out  1  destination select: 0=rt, 1=rd
reg_write  out  1  register file write enable
alu_src_a  out  1  ALU A select: 0=PC, 1=regA
alu_src_b  out  2  ALU B select: 0=regB, 1=const 4, 2=signext, 3=signext<<2
alu_op  out  2  0=add, 1=sub, 2=funct-decoded
pc_source  out  2  PC source: 0=ALU result, 1=ALUOut, 2=jump target
illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode
trap  out  1  high while in HALT
state  out  4  current state encoding, for debug

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; wait counter=0; every output 0.
  - Deassertion mid-instruction is safe: the FSM always restarts from IDLE.
- State encodings:
  - IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12, HALT=15.
- IDLE: all outputs 0; next state is FETCH unconditionally.
- FETCH:
  - Asserts mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - ir_write and pc_write are asserted only when mem_ready=1; go to DECODE on that cycle.
  - Otherwise stay in FETCH.
- DECODE:
  - Asserts alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut).
  - Next state by opcode: 0x00 -> EXEC; 0x23/0x2B -> MEMADR; 0x04 -> BRANCH; 0x02 -> JUMP; 0x08 -> ADDIEX.
  - Any other opcode: illegal_op=1 this cycle, next state FETCH. The PC has already advanced, so the instruction is skipped.
- MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0. Next is MEMRD if opcode=0x23, else MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next is FETCH.
- MEMWR: mem_write=1, i_or_d=1. Hold until mem_ready, then go to FETCH. mem_write stays high for every held cycle.
- EXEC: alu_src_a=1, alu_src_b=0, alu_op=2. Next is ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1. Next is FETCH. The PC load itself (pc_write_cond & zero) is done in the datapath.
- JUMP: pc_write=1, pc_source=2. Next is FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=2, alu_op=0. Next is ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next is FETCH.
- Wait counter:
  - Counts +1 each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on any state change and whenever mem_ready=1.
  - When the counter equals MAX_WAIT and mem_ready=0, next state is HALT. A mem_ready=1 on that same cycle wins: the access completes normally.
- HALT: all strobes 0; trap=1; exit only via reset.
- Output timing:
  - All outputs are combinational from the state register only, except the mem_ready gating of ir_write/pc_write in FETCH and illegal_op in DECODE.
  - No output depends on zero.
- Latencies at zero wait: R-type=4 cycles, lw=5, sw=4, beq=3, j=3, addi=4.

Decomposition:
- Package mips_mc_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - state encodings S_IDLE..S_HALT;
  - ALUOP_ADD/SUB/FUNCT;
  - ALUB_REG/FOUR/IMM/IMM_SH2;
  - PCSRC_ALU/ALUOUT/JUMP.
- One sub-module, mem_wait_timer: counter, clear/enable logic, and the expired flag. It is parameterised by MAX_WAIT and WAIT_W.

Test Plan:
- Reset held for 3 cycles, then released, with mem_ready=1 -> IDLE outputs all 0; FETCH next cycle with mem_read=1, ir_write=1, pc_write=1.
- lw (opcode 0x23), mem_ready always 1 -> state sequence 1,2,3,4,5,1; reg_write=1 with mem_to_reg=1 only in MEMWB; 5 cycles.
- sw (0x2B) with mem_ready low for 3 cycles in MEMWR -> mem_write held for 4 cycles; reg_write never 1; then FETCH.
- beq (0x04) and j (0x02) -> pc_write_cond=1, pc_source=1 in BRANCH; pc_write=1, pc_source=2 in JUMP; each 3 cycles.
- Opcode 0x3F -> illegal_op pulses for 1 cycle in DECODE; next state FETCH; no reg_write or mem_write.
- MAX_WAIT=15, mem_ready=0 in FETCH for 16 cycles -> HALT with trap=1 sticky. Asserting reset mid-HALT returns to IDLE asynchronously with trap=0.
